alu_issue_queue: RTL

- Upstream feeder for the 32-bit ALU. Buffers operand/opcode commands in a small FIFO and drives the ALU's A, B and Opin inputs one command per cycle.
- Tracks each issued command through the ALU's fixed latency and returns the ALU result with its tag and a valid strobe.
- Sits between the command source (bench or controller) and the ALU.

---
 rtl/alu_issue_queue_pkg.sv | 24 ++
 rtl/alu_issue_queue_cmd_fifo.sv | 62 ++++++
 rtl/alu_issue_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU and its issue queue.
//   DATA_W / OP_W / TAG_W : default operand, opcode and tag widths
//   OP_*                  : ALU opcode encodings (opaque to the queue)
//   alu_cmd_t             : one queued command {a, b, op, tag}
package alu_issue_queue_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int TAG_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_AND = 4'b0001;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0100;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_issue_queue_cmd_fifo.sv
// alu_cmd_fifo: DEPTH x WIDTH command FIFO with synchronous flush.
//   clk, reset  : clock, async active-low reset
//   push, wdata : write request and data (ignored when full or flushing)
//   pop, rdata  : read request (ignored when empty or flushing), head data
//   flush       : clears both pointers; wins over push and pop
//   full, empty : occupancy flags from registered pointers only
//   count       : occupancy 0..DEPTH
module alu_cmd_fifo
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  // Extra MSB on each pointer is a wrap bit distinguishing full from empty.
  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; empty gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands, issues one per cycle onto the ALU
// inputs and returns each result with its tag after the ALU latency.
//   clk, reset                  : clock, async active-low reset
//   in_valid/in_ready, in_*     : command input (in_ready = not full)
//   hold                        : pause issue, keep accepting commands
//   flush                       : drop all queued, not-yet-issued commands
//   A, B, Opin, issue_valid     : ALU operand/opcode drive, new-issue strobe
//   alu_result                  : ALU result input
//   res_valid, res_data, res_tag: one-cycle result strobe with data and tag
//   count                       : FIFO occupancy
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DATA_W  = alu_issue_queue_pkg::DATA_W,
  parameter int OP_W    = alu_issue_queue_pkg::OP_W,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = alu_issue_queue_pkg::TAG_W,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_a,
  input  logic [DATA_W-1:0]       in_b,
  input  logic [OP_W-1:0]         in_op,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    hold,
  input  logic                    flush,
  output logic [DATA_W-1:0]       A,
  output logic [DATA_W-1:0]       B,
  output logic [OP_W-1:0]         Opin,
  output logic                    issue_valid,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    res_valid,
  output logic [DATA_W-1:0]       res_data,
  output logic [TAG_W-1:0]        res_tag,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CMD_W = 2*DATA_W + OP_W + TAG_W;

  logic [CMD_W-1:0]  head;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [OP_W-1:0]   head_op;
  logic [TAG_W-1:0]  head_tag;
  logic              full;
  logic              empty;
  logic              pop;

  assign {head_a, head_b, head_op, head_tag} = head;
  assign in_ready = !full;
  assign pop      = !empty && !hold && !flush;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .flush (flush),
    .wdata ({in_a, in_b, in_op, in_tag}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Issue register: A/B/Opin keep their last value when nothing issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A           <= '0;
      B           <= '0;
      Opin        <= '0;
      issue_valid <= 1'b0;
    end else begin
      issue_valid <= pop;
      if (pop) begin
        A    <= head_a;
        B    <= head_b;
        Opin <= head_op;
      end
    end
  end

  // Tag pipe: stage 0 is loaded at the issue edge alongside A/B/Opin; the
  // extra stage beyond ALU_LAT covers the cycle in which the ALU samples its
  // inputs, so the last stage lines up with a valid alu_result.
  logic [ALU_LAT:0] pipe_v;
  logic [TAG_W-1:0] pipe_tag [ALU_LAT+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
      for (int i = 0; i <= ALU_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v      <= {pipe_v[ALU_LAT-1:0], pop};
      pipe_tag[0] <= head_tag;
      for (int i = 1; i <= ALU_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      res_valid <= pipe_v[ALU_LAT];
      if (pipe_v[ALU_LAT]) begin
        res_data <= alu_result;
        res_tag  <= pipe_tag[ALU_LAT];
      end
    end
  end

endmodule
